// File: rtl/csr_file_if.sv
// CSR access bus between the writeback stage and the CSR file.
// The master issues reads and writes; the slave returns combinational read data.
interface csr_file_if;
  logic        csr_re;
  logic [13:0] csr_num;
  logic [31:0] csr_rvalue;
  logic        csr_we;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wvalue;

  modport master (
    output csr_re,
    output csr_num,
    output csr_we,
    output csr_wmask,
    output csr_wvalue,
    input  csr_rvalue
  );

  modport slave (
    input  csr_re,
    input  csr_num,
    input  csr_we,
    input  csr_wmask,
    input  csr_wvalue,
    output csr_rvalue
  );
endinterface

// File: rtl/csr_file.sv
// LoongArch-subset control/status register file.
// Holds exception state, a countdown timer and interrupt sampling, and
// hands the masked interrupt request and entry/return addresses to fetch.
module csr_file #(
  parameter int          SAVE_NUM  = 4,
  parameter int          HWI_NUM   = 8,
  parameter int          TIMER_W   = 32,
  parameter logic [31:0] TID_RESET = 32'h0
) (
  input  logic               clk,
  input  logic               reset,
  csr_file_if.slave          csr_bus,
  input  logic               wb_ex,
  input  logic [5:0]         wb_ecode,
  input  logic [8:0]         wb_esubcode,
  input  logic [31:0]        wb_pc,
  input  logic [31:0]        wb_vaddr,
  input  logic               eret_flush,
  input  logic [HWI_NUM-1:0] hw_int_in,
  input  logic               ipi_int_in,
  output logic               has_int,
  output logic [31:0]        ex_entry,
  output logic [31:0]        era_out
);

  localparam logic [13:0] ADDR_CRMD   = 14'h000;
  localparam logic [13:0] ADDR_PRMD   = 14'h001;
  localparam logic [13:0] ADDR_ECFG   = 14'h004;
  localparam logic [13:0] ADDR_ESTAT  = 14'h005;
  localparam logic [13:0] ADDR_ERA    = 14'h006;
  localparam logic [13:0] ADDR_BADV   = 14'h007;
  localparam logic [13:0] ADDR_EENTRY = 14'h00C;
  localparam logic [13:0] ADDR_TID    = 14'h040;
  localparam logic [13:0] ADDR_TCFG   = 14'h041;
  localparam logic [13:0] ADDR_TVAL   = 14'h042;
  localparam logic [13:0] ADDR_TICLR  = 14'h044;

  // LIE bit 10 has no interrupt source behind it, so it is never stored.
  localparam logic [12:0] LIE_MASK = 13'h1BFF;

  logic [1:0]         crmd_plv;
  logic               crmd_ie;
  logic               crmd_da;
  logic [1:0]         prmd_pplv;
  logic               prmd_pie;
  logic [12:0]        ecfg_lie;
  logic [1:0]         is_sw;
  logic [HWI_NUM-1:0] is_hw;
  logic               is_timer;
  logic               is_ipi;
  logic [5:0]         estat_ecode;
  logic [8:0]         estat_esubcode;
  logic [31:0]        era;
  logic [31:0]        badv;
  logic [25:0]        eentry_va;
  logic [31:0]        save_q [SAVE_NUM];
  logic [31:0]        tid;
  logic [TIMER_W-1:0] tcfg;
  logic [TIMER_W-1:0] cnt;

  logic [12:0]        is_full;
  logic [31:0]        cnt_ext;
  logic [31:0]        tcfg_ext;
  logic [31:0]        rd_raw;
  logic [31:0]        wr_data;
  logic               csr_wr;
  logic               save_hit;
  logic               timer_expire;

  // Software writes lose to exception entry and return in the same cycle.
  assign csr_wr       = csr_bus.csr_we & ~wb_ex & ~eret_flush;
  assign save_hit     = (csr_bus.csr_num[13:4] == 10'h003);
  assign timer_expire = tcfg[0] & (cnt == '0);

  // Assemble the interrupt status vector and zero-extend the timer fields.
  always_comb begin
    is_full     = '0;
    is_full[1:0] = is_sw;
    for (int i = 0; i < HWI_NUM; i++) begin
      is_full[2+i] = is_hw[i];
    end
    is_full[11] = is_timer;
    is_full[12] = is_ipi;
    cnt_ext  = '0;
    cnt_ext[TIMER_W-1:0]  = cnt;
    tcfg_ext = '0;
    tcfg_ext[TIMER_W-1:0] = tcfg;
  end

  // Address decode for reads; also the "old" value for masked writes.
  always_comb begin
    rd_raw = '0;
    case (csr_bus.csr_num)
      ADDR_CRMD:   rd_raw = {28'b0, crmd_da, crmd_ie, crmd_plv};
      ADDR_PRMD:   rd_raw = {29'b0, prmd_pie, prmd_pplv};
      ADDR_ECFG:   rd_raw = {19'b0, ecfg_lie};
      ADDR_ESTAT:  rd_raw = {1'b0, estat_esubcode, estat_ecode, 3'b0, is_full};
      ADDR_ERA:    rd_raw = era;
      ADDR_BADV:   rd_raw = badv;
      ADDR_EENTRY: rd_raw = {eentry_va, 6'b0};
      ADDR_TID:    rd_raw = tid;
      ADDR_TCFG:   rd_raw = tcfg_ext;
      ADDR_TVAL:   rd_raw = cnt_ext;
      default: begin
        for (int i = 0; i < SAVE_NUM; i++) begin
          if (save_hit && (csr_bus.csr_num[3:0] == 4'(i))) begin
            rd_raw = save_q[i];
          end
        end
      end
    endcase
  end

  assign csr_bus.csr_rvalue = csr_bus.csr_re ? rd_raw : 32'h0;
  assign wr_data = (csr_bus.csr_wmask & csr_bus.csr_wvalue) |
                   (~csr_bus.csr_wmask & rd_raw);

  // Current mode: exception entry drops to kernel with interrupts off, ERTN restores.
  always_ff @(posedge clk) begin
    if (reset) begin
      crmd_plv <= 2'b0;
      crmd_ie  <= 1'b0;
      crmd_da  <= 1'b1;
    end else if (wb_ex) begin
      crmd_plv <= 2'b0;
      crmd_ie  <= 1'b0;
    end else if (eret_flush) begin
      crmd_plv <= prmd_pplv;
      crmd_ie  <= prmd_pie;
    end else if (csr_wr && csr_bus.csr_num == ADDR_CRMD) begin
      crmd_plv <= wr_data[1:0];
      crmd_ie  <= wr_data[2];
      crmd_da  <= wr_data[3];
    end
  end

  // Previous mode captures CRMD on exception entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      prmd_pplv <= 2'b0;
      prmd_pie  <= 1'b0;
    end else if (wb_ex) begin
      prmd_pplv <= crmd_plv;
      prmd_pie  <= crmd_ie;
    end else if (csr_wr && csr_bus.csr_num == ADDR_PRMD) begin
      prmd_pplv <= wr_data[1:0];
      prmd_pie  <= wr_data[2];
    end
  end

  // Exception config and entry address, software-written only.
  always_ff @(posedge clk) begin
    if (reset) begin
      ecfg_lie  <= '0;
      eentry_va <= '0;
    end else begin
      if (csr_wr && csr_bus.csr_num == ADDR_ECFG) begin
        ecfg_lie <= wr_data[12:0] & LIE_MASK;
      end
      if (csr_wr && csr_bus.csr_num == ADDR_EENTRY) begin
        eentry_va <= wr_data[31:6];
      end
    end
  end

  // Interrupt lines are resampled every cycle regardless of other activity.
  always_ff @(posedge clk) begin
    if (reset) begin
      is_hw  <= '0;
      is_ipi <= 1'b0;
    end else begin
      is_hw  <= hw_int_in;
      is_ipi <= ipi_int_in;
    end
  end

  // Software interrupt bits and the exception cause fields.
  always_ff @(posedge clk) begin
    if (reset) begin
      is_sw          <= 2'b0;
      estat_ecode    <= '0;
      estat_esubcode <= '0;
    end else if (wb_ex) begin
      estat_ecode    <= wb_ecode;
      estat_esubcode <= wb_esubcode;
    end else if (csr_wr && csr_bus.csr_num == ADDR_ESTAT) begin
      is_sw <= wr_data[1:0];
    end
  end

  // Return address and bad address; BADV only moves for address-error causes.
  always_ff @(posedge clk) begin
    if (reset) begin
      era  <= '0;
      badv <= '0;
    end else if (wb_ex) begin
      era <= wb_pc;
      if (wb_ecode == 6'h08 && wb_esubcode == 9'h000) begin
        badv <= wb_pc;
      end else if (wb_ecode == 6'h08 || wb_ecode == 6'h09) begin
        badv <= wb_vaddr;
      end
    end else if (csr_wr) begin
      if (csr_bus.csr_num == ADDR_ERA)  era  <= wr_data;
      if (csr_bus.csr_num == ADDR_BADV) badv <= wr_data;
    end
  end

  // Scratch registers and the timer id.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SAVE_NUM; i++) begin
        save_q[i] <= '0;
      end
      tid <= TID_RESET;
    end else if (csr_wr) begin
      for (int i = 0; i < SAVE_NUM; i++) begin
        if (save_hit && (csr_bus.csr_num[3:0] == 4'(i))) begin
          save_q[i] <= wr_data;
        end
      end
      if (csr_bus.csr_num == ADDR_TID) begin
        tid <= wr_data;
      end
    end
  end

  // Timer config; a write that enables the timer also reloads the counter below.
  always_ff @(posedge clk) begin
    if (reset) begin
      tcfg <= '0;
    end else if (csr_wr && csr_bus.csr_num == ADDR_TCFG) begin
      tcfg <= wr_data[TIMER_W-1:0];
    end
  end

  // Countdown: all-ones is the idle value a one-shot timer parks at.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '1;
    end else if (csr_wr && csr_bus.csr_num == ADDR_TCFG && wr_data[0]) begin
      cnt <= {wr_data[TIMER_W-1:2], 2'b00};
    end else if (tcfg[0] && cnt != '1) begin
      if (cnt == '0 && tcfg[1]) begin
        cnt <= {tcfg[TIMER_W-1:2], 2'b00};
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  // Timer interrupt latch; an expiry in the same cycle as a TICLR clear wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      is_timer <= 1'b0;
    end else if (timer_expire) begin
      is_timer <= 1'b1;
    end else if (csr_wr && csr_bus.csr_num == ADDR_TICLR && wr_data[0]) begin
      is_timer <= 1'b0;
    end
  end

  assign has_int  = crmd_ie & (|(is_full & ecfg_lie));
  assign ex_entry = {eentry_va, 6'b0};
  assign era_out  = era;

endmodule

// File: tb/tb_csr_file.sv
// Directed self-checking bench for csr_file: reset state, timer modes,
// interrupt masking, exception entry/return and address decode.
module tb_csr_file;
  localparam logic [31:0] TIDR = 32'hA5A5_0001;

  logic        clk;
  logic        reset;
  logic        wb_ex;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_pc;
  logic [31:0] wb_vaddr;
  logic        eret_flush;
  logic [7:0]  hw_int_in;
  logic        ipi_int_in;
  logic        has_int;
  logic [31:0] ex_entry;
  logic [31:0] era_out;
  logic [31:0] rd;
  int          checks;
  int          errors;

  csr_file_if bus ();

  csr_file #(
    .SAVE_NUM (4),
    .HWI_NUM  (8),
    .TIMER_W  (32),
    .TID_RESET(TIDR)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .csr_bus    (bus),
    .wb_ex      (wb_ex),
    .wb_ecode   (wb_ecode),
    .wb_esubcode(wb_esubcode),
    .wb_pc      (wb_pc),
    .wb_vaddr   (wb_vaddr),
    .eret_flush (eret_flush),
    .hw_int_in  (hw_int_in),
    .ipi_int_in (ipi_int_in),
    .has_int    (has_int),
    .ex_entry   (ex_entry),
    .era_out    (era_out)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_write(input logic [13:0] num, input logic [31:0] mask, input logic [31:0] val);
    bus.csr_we     = 1'b1;
    bus.csr_num    = num;
    bus.csr_wmask  = mask;
    bus.csr_wvalue = val;
    tick();
    bus.csr_we = 1'b0;
  endtask

  task automatic csr_read(input logic [13:0] num, output logic [31:0] data);
    bus.csr_re  = 1'b1;
    bus.csr_num = num;
    #1;
    data = bus.csr_rvalue;
    bus.csr_re = 1'b0;
  endtask

  task automatic do_ex(input logic [5:0] ec, input logic [8:0] esub, input logic [31:0] pc, input logic [31:0] va);
    wb_ex = 1'b1; wb_ecode = ec; wb_esubcode = esub; wb_pc = pc; wb_vaddr = va;
    tick();
    wb_ex = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    csr_read(14'h000, rd);
    checks++; if (rd !== 32'h8) begin errors++; $display("[TB] FAIL reset_crmd got %h want %h", rd, 32'h8); end
    csr_read(14'h040, rd);
    checks++; if (rd !== TIDR) begin errors++; $display("[TB] FAIL reset_tid got %h want %h", rd, TIDR); end
    csr_read(14'h042, rd);
    checks++; if (rd !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL reset_tval got %h want ffffffff", rd); end
    checks++; if (has_int !== 1'b0 || ex_entry !== 32'h0 || era_out !== 32'h0) begin
      errors++; $display("[TB] FAIL reset_outputs got has_int=%b entry=%h era=%h want 0/0/0", has_int, ex_entry, era_out);
    end
    bus.csr_re = 1'b0; bus.csr_num = 14'h000; #1;
    checks++; if (bus.csr_rvalue !== 32'h0) begin errors++; $display("[TB] FAIL re_low got %h want 0", bus.csr_rvalue); end
  endtask

  task automatic test_timer_periodic();
    csr_write(14'h041, 32'hFFFF_FFFF, 32'h0000_000F);
    csr_read(14'h042, rd);
    checks++; if (rd !== 32'd12) begin errors++; $display("[TB] FAIL per_load got %0d want 12", rd); end
    for (int k = 11; k >= 0; k--) begin
      tick();
      csr_read(14'h042, rd);
      checks++; if (rd !== 32'(k)) begin errors++; $display("[TB] FAIL per_count got %0d want %0d", rd, k); end
      csr_read(14'h005, rd);
      checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL per_is_early got %h want 0", rd); end
    end
    tick();
    csr_read(14'h042, rd);
    checks++; if (rd !== 32'd12) begin errors++; $display("[TB] FAIL per_reload got %0d want 12", rd); end
    csr_read(14'h005, rd);
    checks++; if (rd !== 32'h800) begin errors++; $display("[TB] FAIL per_is_set got %h want 800", rd); end
    tick();
    csr_read(14'h005, rd);
    checks++; if (rd !== 32'h800) begin errors++; $display("[TB] FAIL per_is_hold got %h want 800", rd); end
    csr_write(14'h044, 32'h0000_0001, 32'h0000_0001);
    csr_read(14'h005, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL ticlr_clear got %h want 0", rd); end
    csr_read(14'h044, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL ticlr_read got %h want 0", rd); end
    csr_read(14'h041, rd);
    checks++; if (rd !== 32'hF) begin errors++; $display("[TB] FAIL tcfg_read got %h want f", rd); end
    csr_write(14'h041, 32'hFFFF_FFFF, 32'h0);
    tick();
    csr_read(14'h042, rd);
    checks++; if (rd !== 32'd9) begin errors++; $display("[TB] FAIL timer_stop got %0d want 9", rd); end
  endtask

  task automatic test_timer_oneshot();
    csr_write(14'h041, 32'hFFFF_FFFF, 32'h0000_0009);
    for (int k = 7; k >= 0; k--) begin
      tick();
      csr_read(14'h042, rd);
      checks++; if (rd !== 32'(k)) begin errors++; $display("[TB] FAIL os_count got %0d want %0d", rd, k); end
    end
    tick();
    csr_read(14'h042, rd);
    checks++; if (rd !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL os_park got %h want ffffffff", rd); end
    csr_read(14'h005, rd);
    checks++; if (rd !== 32'h800) begin errors++; $display("[TB] FAIL os_is_set got %h want 800", rd); end
    csr_write(14'h044, 32'h0000_0001, 32'h0000_0001);
    for (int k = 0; k < 4; k++) begin
      tick();
      csr_read(14'h042, rd);
      checks++; if (rd !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL os_stay got %h want ffffffff", rd); end
      csr_read(14'h005, rd);
      checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL os_once got %h want 0", rd); end
    end
  endtask

  task automatic test_set_clear_race();
    csr_write(14'h041, 32'hFFFF_FFFF, 32'h0000_0003);
    tick();
    csr_read(14'h005, rd);
    checks++; if (rd !== 32'h800) begin errors++; $display("[TB] FAIL race_set got %h want 800", rd); end
    csr_write(14'h044, 32'h0000_0001, 32'h0000_0001);
    csr_read(14'h005, rd);
    checks++; if (rd !== 32'h800) begin errors++; $display("[TB] FAIL race_set_wins got %h want 800", rd); end
    csr_write(14'h041, 32'hFFFF_FFFF, 32'h0);
    csr_write(14'h044, 32'hFFFF_FFFE, 32'h0000_0001);
    csr_read(14'h005, rd);
    checks++; if (rd !== 32'h800) begin errors++; $display("[TB] FAIL ticlr_masked got %h want 800", rd); end
    csr_write(14'h044, 32'h0000_0001, 32'h0000_0001);
    csr_read(14'h005, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL race_clear got %h want 0", rd); end
  endtask

  task automatic test_interrupts();
    csr_write(14'h000, 32'h0000_0004, 32'h0000_0004);
    csr_read(14'h000, rd);
    checks++; if (rd !== 32'hC) begin errors++; $display("[TB] FAIL crmd_ie got %h want c", rd); end
    csr_write(14'h004, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    csr_read(14'h004, rd);
    checks++; if (rd !== 32'h1BFF) begin errors++; $display("[TB] FAIL ecfg_mask got %h want 1bff", rd); end
    csr_write(14'h004, 32'hFFFF_FFFF, 32'h0000_0004);
    hw_int_in = 8'h81;
    #1;
    checks++; if (has_int !== 1'b0) begin errors++; $display("[TB] FAIL hwi_latency got %b want 0", has_int); end
    tick();
    checks++; if (has_int !== 1'b1) begin errors++; $display("[TB] FAIL hwi_has_int got %b want 1", has_int); end
    csr_read(14'h005, rd);
    checks++; if (rd !== 32'h204) begin errors++; $display("[TB] FAIL hwi_estat got %h want 204", rd); end
    csr_write(14'h004, 32'hFFFF_FFFF, 32'h0);
    checks++; if (has_int !== 1'b0) begin errors++; $display("[TB] FAIL lie_off got %b want 0", has_int); end
    hw_int_in  = 8'h00;
    ipi_int_in = 1'b1;
    csr_write(14'h004, 32'hFFFF_FFFF, 32'h0000_1000);
    checks++; if (has_int !== 1'b1) begin errors++; $display("[TB] FAIL ipi_has_int got %b want 1", has_int); end
    csr_read(14'h005, rd);
    checks++; if (rd !== 32'h1000) begin errors++; $display("[TB] FAIL ipi_estat got %h want 1000", rd); end
    ipi_int_in = 1'b0;
    csr_write(14'h005, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    csr_read(14'h005, rd);
    checks++; if (rd !== 32'h3) begin errors++; $display("[TB] FAIL swi_estat got %h want 3", rd); end
    csr_write(14'h004, 32'hFFFF_FFFF, 32'h0000_0001);
    checks++; if (has_int !== 1'b1) begin errors++; $display("[TB] FAIL swi_has_int got %b want 1", has_int); end
    csr_write(14'h000, 32'h0000_0004, 32'h0);
    checks++; if (has_int !== 1'b0) begin errors++; $display("[TB] FAIL ie_off got %b want 0", has_int); end
    csr_write(14'h005, 32'hFFFF_FFFF, 32'h0);
    csr_write(14'h004, 32'hFFFF_FFFF, 32'h0);
  endtask

  task automatic test_exception();
    csr_write(14'h000, 32'h0000_0007, 32'h0000_0007);
    csr_write(14'h030, 32'hFFFF_FFFF, 32'h1111_2222);
    bus.csr_we = 1'b1; bus.csr_num = 14'h030; bus.csr_wmask = 32'hFFFF_FFFF; bus.csr_wvalue = 32'hDEAD_BEEF;
    do_ex(6'h09, 9'h000, 32'h1C00_0100, 32'h0000_1003);
    bus.csr_we = 1'b0;
    checks++; if (era_out !== 32'h1C00_0100) begin errors++; $display("[TB] FAIL ex_era_out got %h want 1c000100", era_out); end
    csr_read(14'h007, rd);
    checks++; if (rd !== 32'h0000_1003) begin errors++; $display("[TB] FAIL ex_badv_ale got %h want 1003", rd); end
    csr_read(14'h000, rd);
    checks++; if (rd !== 32'h8) begin errors++; $display("[TB] FAIL ex_crmd got %h want 8", rd); end
    csr_read(14'h001, rd);
    checks++; if (rd !== 32'h7) begin errors++; $display("[TB] FAIL ex_prmd got %h want 7", rd); end
    csr_read(14'h005, rd);
    checks++; if (rd !== 32'h0009_0000) begin errors++; $display("[TB] FAIL ex_estat got %h want 00090000", rd); end
    csr_read(14'h030, rd);
    checks++; if (rd !== 32'h1111_2222) begin errors++; $display("[TB] FAIL ex_save_blocked got %h want 11112222", rd); end
    eret_flush = 1'b1;
    csr_write(14'h000, 32'hFFFF_FFFF, 32'h0);
    eret_flush = 1'b0;
    csr_read(14'h000, rd);
    checks++; if (rd !== 32'hF) begin errors++; $display("[TB] FAIL eret_crmd got %h want f", rd); end
    do_ex(6'h08, 9'h000, 32'h2000_0040, 32'h0000_5555);
    csr_read(14'h007, rd);
    checks++; if (rd !== 32'h2000_0040) begin errors++; $display("[TB] FAIL ex_badv_adef got %h want 20000040", rd); end
    do_ex(6'h08, 9'h001, 32'h2000_0080, 32'h0000_6666);
    csr_read(14'h007, rd);
    checks++; if (rd !== 32'h0000_6666) begin errors++; $display("[TB] FAIL ex_badv_adem got %h want 6666", rd); end
    csr_read(14'h005, rd);
    checks++; if (rd !== 32'h0048_0000) begin errors++; $display("[TB] FAIL ex_esub got %h want 00480000", rd); end
    do_ex(6'h03, 9'h000, 32'h2000_00C0, 32'h0000_7777);
    csr_read(14'h007, rd);
    checks++; if (rd !== 32'h0000_6666) begin errors++; $display("[TB] FAIL ex_badv_keep got %h want 6666", rd); end
    csr_read(14'h006, rd);
    checks++; if (rd !== 32'h2000_00C0) begin errors++; $display("[TB] FAIL ex_era got %h want 200000c0", rd); end
  endtask

  task automatic test_decode();
    csr_write(14'h034, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    csr_read(14'h034, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL save_oob got %h want 0", rd); end
    csr_write(14'h07F, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    csr_read(14'h07F, rd);
    checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL unimpl got %h want 0", rd); end
    csr_write(14'h033, 32'hFFFF_FFFF, 32'hCAFE_0003);
    csr_read(14'h033, rd);
    checks++; if (rd !== 32'hCAFE_0003) begin errors++; $display("[TB] FAIL save_last got %h want cafe0003", rd); end
    csr_read(14'h030, rd);
    checks++; if (rd !== 32'h1111_2222) begin errors++; $display("[TB] FAIL save0_keep got %h want 11112222", rd); end
    csr_write(14'h00C, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    csr_read(14'h00C, rd);
    checks++; if (rd !== 32'hFFFF_FFC0) begin errors++; $display("[TB] FAIL eentry_low got %h want ffffffc0", rd); end
    csr_write(14'h00C, 32'hFFFF_0000, 32'h1234_5678);
    csr_read(14'h00C, rd);
    checks++; if (rd !== 32'h1234_FFC0) begin errors++; $display("[TB] FAIL eentry_mask got %h want 1234ffc0", rd); end
    checks++; if (ex_entry !== 32'h1234_FFC0) begin errors++; $display("[TB] FAIL ex_entry got %h want 1234ffc0", ex_entry); end
    csr_write(14'h040, 32'h0000_FFFF, 32'h0000_BEEF);
    csr_read(14'h040, rd);
    checks++; if (rd !== 32'hA5A5_BEEF) begin errors++; $display("[TB] FAIL tid_mask got %h want a5a5beef", rd); end
  endtask

  // Run every scenario in order, then print the summary.
  initial begin
    checks = 0; errors = 0;
    reset = 1'b1;
    wb_ex = 1'b0; wb_ecode = '0; wb_esubcode = '0; wb_pc = '0; wb_vaddr = '0;
    eret_flush = 1'b0; hw_int_in = '0; ipi_int_in = 1'b0;
    bus.csr_re = 1'b0; bus.csr_num = '0; bus.csr_we = 1'b0;
    bus.csr_wmask = '0; bus.csr_wvalue = '0;
    test_reset();
    test_timer_periodic();
    test_timer_oneshot();
    test_set_clear_race();
    test_interrupts();
    test_exception();
    test_decode();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
